// File: rtl/ewb_pkg.sv
// Shared types and default parameters for the eviction write-back queue.
package ewb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMemRd = 2'd1,
    StMemWr = 2'd2
  } ewb_state_e;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefAddrW = 12;
  localparam int unsigned DefLineW = 128;
  localparam int unsigned DefEager = 1;

endpackage

// File: rtl/ewb_match.sv
// Parallel line-address compare over the queue; reports the youngest matching entry.
module ewb_match #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]        valid_i,
  input  logic [DEPTH*ADDR_W-1:0] adr_i,
  input  logic [ADDR_W-1:0]       key_i,
  input  logic [PTR_W-1:0]        head_i,
  input  logic                    excl_head_i,
  output logic                    hit_o,
  output logic [PTR_W-1:0]        idx_o
);

  logic [PTR_W-1:0] slot;

  // Walk from oldest (head) to youngest so the last hit found wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot  = '0;
    for (int unsigned age = 0; age < DEPTH; age++) begin
      slot = head_i + PTR_W'(age);
      if (valid_i[slot] && (adr_i[slot*ADDR_W +: ADDR_W] == key_i) &&
          !(excl_head_i && (age == 0))) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/ewb_queue.sv
// Eviction write-back queue between L2 and memory: coalesces evictions, forwards
// reads from queued lines, and drains entries to memory one transaction at a time.
module ewb_queue
  import ewb_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LINE_W = DefLineW,
  parameter int unsigned EAGER  = DefEager
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   l2_stb,
  input  logic                   l2_we,
  input  logic [ADDR_W-1:0]      l2_adr,
  input  logic [LINE_W-1:0]      l2_wdat,
  output logic [LINE_W-1:0]      l2_rdat,
  output logic                   l2_ack,
  output logic                   mem_cyc,
  output logic                   mem_stb,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_adr,
  output logic [LINE_W-1:0]      mem_wdat,
  input  logic [LINE_W-1:0]      mem_rdat,
  input  logic                   mem_ack,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ewb_state_e state_q, state_d;

  logic [PTR_W-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  adr_q;
  logic [DEPTH-1:0][LINE_W-1:0]  data_q;
  logic [ADDR_W-1:0]             rd_adr_q, rd_adr_d;
  logic                          l2_ack_q, l2_ack_d;
  logic [LINE_W-1:0]             l2_rdat_q, l2_rdat_d;

  logic             locked, req_ok, hit, wr_acc, coalesce, push, pop;
  logic             rd_hit, rd_miss, rd_done, drain_ok;
  logic [PTR_W-1:0] hit_idx, wr_idx;

  // The head is frozen while it is being written out, so writes must not land on it.
  assign locked = (state_q == StMemWr);

  ewb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_match (
    .valid_i     (valid_q),
    .adr_i       (adr_q),
    .key_i       (l2_adr),
    .head_i      (head_q),
    .excl_head_i (l2_we && locked),
    .hit_o       (hit),
    .idx_o       (hit_idx)
  );

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pending read miss holds l2_stb through MEM_RD, so new requests are ignored there.
  always_comb begin
    req_ok   = l2_stb && !l2_ack_q && (state_q != StMemRd);
    wr_acc   = req_ok && l2_we && (hit || !full);
    coalesce = wr_acc && hit;
    push     = wr_acc && !hit;
    rd_hit   = req_ok && !l2_we && hit;
    rd_miss  = req_ok && !l2_we && !hit;
    rd_done  = (state_q == StMemRd) && mem_ack;
    pop      = locked && mem_ack;
    drain_ok = !empty && ((EAGER != 0) || !l2_stb || full);
    wr_idx   = push ? tail_q : hit_idx;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_miss) begin
          state_d = StMemRd;
        end else if (drain_ok) begin
          state_d = StMemWr;
        end
      end
      StMemRd, StMemWr: begin
        if (mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    head_d    = head_q + PTR_W'(pop);
    tail_d    = tail_q + PTR_W'(push);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    valid_d   = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
    end
    rd_adr_d  = ((state_q == StIdle) && rd_miss) ? l2_adr : rd_adr_q;
    l2_ack_d  = wr_acc || rd_hit || rd_done;
    l2_rdat_d = l2_rdat_q;
    if (rd_hit) begin
      l2_rdat_d = data_q[hit_idx];
    end else if (rd_done) begin
      l2_rdat_d = mem_rdat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      adr_q     <= '0;
      rd_adr_q  <= '0;
      l2_ack_q  <= 1'b0;
      l2_rdat_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      rd_adr_q  <= rd_adr_d;
      l2_ack_q  <= l2_ack_d;
      l2_rdat_q <= l2_rdat_d;
      if (push) begin
        adr_q[tail_q] <= l2_adr;
      end
    end
  end

  // Line data is qualified by valid_q and never reaches an output unqualified.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      data_q[wr_idx] <= l2_wdat;
    end
  end

  always_comb begin
    mem_cyc  = (state_q != StIdle);
    mem_stb  = (state_q != StIdle);
    mem_we   = (state_q == StMemWr);
    mem_adr  = '0;
    mem_wdat = '0;
    if (state_q == StMemWr) begin
      mem_adr  = adr_q[head_q];
      mem_wdat = data_q[head_q];
    end else if (state_q == StMemRd) begin
      mem_adr = rd_adr_q;
    end
  end

  assign l2_ack  = l2_ack_q;
  assign l2_rdat = l2_rdat_q;

endmodule

// File: tb/tb_ewb_queue.sv
// Randomised and directed bench for ewb_queue with a scoreboard and a coherent-memory model.
module tb_ewb_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LINE_W = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              l2_stb, l2_we, l2_ack, mem_cyc, mem_stb, mem_we, mem_ack, full, empty;
  logic [ADDR_W-1:0] l2_adr, mem_adr;
  logic [LINE_W-1:0] l2_wdat, l2_rdat, mem_wdat, mem_rdat;
  logic [2:0]        count;

  logic              lz_stb, lz_we, lz_ack, lz_mem_cyc, lz_mem_stb, lz_mem_we, lz_mem_ack;
  logic              lz_full, lz_empty;
  logic [ADDR_W-1:0] lz_adr, lz_mem_adr;
  logic [LINE_W-1:0] lz_wdat, lz_rdat, lz_mem_wdat;
  logic [2:0]        lz_count;

  ewb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .EAGER(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr),
    .l2_wdat(l2_wdat), .l2_rdat(l2_rdat), .l2_ack(l2_ack), .mem_cyc(mem_cyc),
    .mem_stb(mem_stb), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat), .mem_ack(mem_ack), .count(count), .full(full), .empty(empty)
  );

  ewb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .EAGER(0)) u_lazy (
    .clk(clk), .rst_n(rst_n), .l2_stb(lz_stb), .l2_we(lz_we), .l2_adr(lz_adr),
    .l2_wdat(lz_wdat), .l2_rdat(lz_rdat), .l2_ack(lz_ack), .mem_cyc(lz_mem_cyc),
    .mem_stb(lz_mem_stb), .mem_we(lz_mem_we), .mem_adr(lz_mem_adr), .mem_wdat(lz_mem_wdat),
    .mem_rdat('0), .mem_ack(lz_mem_ack), .count(lz_count), .full(lz_full), .empty(lz_empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected response", name);
  endtask

  // Backing memory seen by the DUT, and the value every address should read back as.
  logic [LINE_W-1:0] mem_arr [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] shadow  [logic [ADDR_W-1:0]];
  int                memwr_cnt  [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] memwr_last [logic [ADDR_W-1:0]];

  function automatic logic [LINE_W-1:0] init_val(logic [ADDR_W-1:0] a);
    return {8{4'hC, a}};
  endfunction

  function automatic logic [LINE_W-1:0] mem_val(logic [ADDR_W-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return init_val(a);
  endfunction

  function automatic logic [LINE_W-1:0] shadow_val(logic [ADDR_W-1:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  bit auto_mem = 1'b0;

  task automatic mem_respond();
    mem_ack = 1'b1;
    if (mem_we) mem_arr[mem_adr] = mem_wdat;
    else mem_rdat = mem_val(mem_adr);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_mem) begin
        if (mem_ack) mem_ack = 1'b0;
        else if (mem_stb && ($urandom_range(0, 2) == 0)) mem_respond();
      end
    end
  end

  // Scoreboard of L2 responses and an ordered model of the lines still owed to memory.
  typedef struct {
    bit                rd;
    logic [LINE_W-1:0] data;
  } exp_t;
  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [LINE_W-1:0] data;
  } ent_t;

  exp_t sb_q[$];
  ent_t mq[$];

  bit                mon_en = 1'b0;
  int                ack_cnt = 0;
  int                rd_cycles = 0;
  bit                prev_wr_req, prev_mwr, prev_mack;
  logic [ADDR_W-1:0] prev_adr, prev_madr;
  logic [LINE_W-1:0] prev_wdat, prev_mwdat;

  function automatic void apply_write(logic [ADDR_W-1:0] a, logic [LINE_W-1:0] d, bit lock);
    int hit_i = -1;
    int lo = lock ? 1 : 0;
    ent_t e;
    for (int i = int'(mq.size()) - 1; i >= lo; i--) begin
      if (mq[i].adr == a) begin
        hit_i = i;
        break;
      end
    end
    if (hit_i >= 0) begin
      mq[hit_i].data = d;
    end else begin
      e.adr  = a;
      e.data = d;
      mq.push_back(e);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_wr_req = 1'b0;
        prev_mwr    = 1'b0;
        prev_mack   = 1'b0;
      end else begin
        if (l2_ack) begin
          ack_cnt++;
          if (sb_q.size() == 0) begin
            fail_now("spurious_l2_ack");
          end else begin
            e = sb_q.pop_front();
            if (e.rd) chk("l2_rdat", l2_rdat, e.data);
          end
          if (prev_wr_req) apply_write(prev_adr, prev_wdat, prev_mwr);
        end
        if (prev_mwr && prev_mack) begin
          if (mq.size() == 0) begin
            fail_now("unexpected_mem_write");
          end else begin
            chk("mem_wr_adr", prev_madr, mq[0].adr);
            chk("mem_wr_dat", prev_mwdat, mq[0].data);
            void'(mq.pop_front());
          end
          memwr_cnt[prev_madr]++;
          memwr_last[prev_madr] = prev_mwdat;
        end
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("cyc_eq_stb", mem_cyc, mem_stb);
        if (mem_stb && !mem_we) rd_cycles++;
        prev_wr_req = l2_stb && l2_we && !l2_ack;
        prev_adr    = l2_adr;
        prev_wdat   = l2_wdat;
        prev_mwr    = mem_stb && mem_we;
        prev_mack   = mem_ack;
        prev_madr   = mem_adr;
        prev_mwdat  = mem_wdat;
      end
    end
  end

  int last_lat;

  task automatic do_req(bit we, logic [ADDR_W-1:0] a, logic [LINE_W-1:0] d);
    exp_t e;
    int   n = 0;
    e.rd   = !we;
    e.data = we ? '0 : shadow_val(a);
    if (we) shadow[a] = d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    l2_stb  = 1'b1;
    l2_we   = we;
    l2_adr  = a;
    l2_wdat = d;
    forever begin
      @(negedge clk);
      if (l2_ack) break;
      n++;
      if (n > 400) break;
    end
    last_lat = n;
    if (n > 400) fail_now("l2_ack_timeout");
    @(posedge clk);
    #1;
    l2_stb = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!(count == 0 && !mem_stb) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail_now("drain_timeout");
  endtask

  task automatic wait_memwr();
    int n = 0;
    while (!(mem_stb && mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("mem_write_start");
  endtask

  task automatic mem_pulse();
    @(posedge clk);
    #1;
    mem_respond();
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] da, db, dc;
    int rd0, a0, viol, n;
    l2_stb = 0; l2_we = 0; l2_adr = '0; l2_wdat = '0;
    mem_ack = 0; mem_rdat = '0;
    lz_stb = 0; lz_we = 0; lz_adr = '0; lz_wdat = '0; lz_mem_ack = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_l2_ack", l2_ack, 0);
    chk("rst_mem_cyc", mem_cyc, 0);
    chk("rst_mem_stb", mem_stb, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_l2_rdat", l2_rdat, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_wdat", mem_wdat, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // EAGER=0: requests held back-to-back must not trigger a drain until full.
    viol = 0;
    @(posedge clk);
    #1;
    lz_stb = 1'b1;
    lz_we  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lz_adr  = 12'h100 + 12'(k);
      lz_wdat = LINE_W'(k);
      n = 0;
      do begin
        @(negedge clk);
        if (lz_mem_stb) viol++;
        n++;
      end while (!lz_ack && n < 50);
      if (!lz_ack) fail_now("lazy_ack_timeout");
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    chk("lazy_no_drain", viol, 0);
    chk("lazy_cnt4", lz_count, 4);
    @(posedge clk);
    #1;
    lz_stb = 1'b0;
    @(negedge clk);
    chk("lazy_full_drain", lz_mem_stb, 1);
    @(posedge clk);
    #1;
    lz_mem_ack = 1'b1;
    @(posedge clk);
    #1;
    lz_mem_ack = 1'b0;
    @(negedge clk);
    chk("lazy_pop_cnt", lz_count, 3);
    chk("lazy_idle_gap", lz_mem_stb, 0);
    @(negedge clk);
    chk("lazy_idle_drain", lz_mem_stb, 1);

    // Read hit served from the queue while memory is stalled.
    do_req(1'b1, 12'h010, {4{32'h1111_0010}});
    do_req(1'b1, 12'h020, {4{32'h2222_0020}});
    rd0 = rd_cycles;
    do_req(1'b0, 12'h020, '0);
    chk("rd_hit_lat", last_lat, 1);
    repeat (2) @(negedge clk);
    chk("rd_hit_no_mem_rd", rd_cycles - rd0, 0);
    auto_mem = 1'b1;
    wait_empty();

    // Coalescing behind a locked head.
    auto_mem = 1'b0;
    da = {4{32'hAAAA_0030}};
    db = {4{32'hBBBB_0030}};
    do_req(1'b1, 12'h050, {4{32'h5050_5050}});
    wait_memwr();
    do_req(1'b1, 12'h030, da);
    do_req(1'b1, 12'h030, db);
    @(negedge clk);
    chk("coalesce_cnt", count, 2);
    auto_mem = 1'b1;
    wait_empty();
    chk("coalesce_writes", memwr_cnt[12'h030], 1);
    chk("coalesce_data", memwr_last[12'h030], db);

    // Locked head: matching write must push a second entry.
    auto_mem = 1'b0;
    dc = {4{32'hCCCC_0040}};
    do_req(1'b1, 12'h040, {4{32'h0C0C_0040}});
    wait_memwr();
    do_req(1'b1, 12'h040, dc);
    @(negedge clk);
    chk("locked_push_cnt", count, 2);
    auto_mem = 1'b1;
    wait_empty();
    chk("locked_writes", memwr_cnt[12'h040], 2);
    chk("locked_data", memwr_last[12'h040], dc);

    // Full stall, then accept one cycle after a pop.
    auto_mem = 1'b0;
    for (int k = 0; k < 4; k++) do_req(1'b1, 12'h0A0 + 12'(k), {4{32'h0A0 + 32'(k)}});
    fork
      do_req(1'b1, 12'h0E0, {4{32'hE0E0_E0E0}});
      begin
        a0 = ack_cnt;
        repeat (6) @(negedge clk);
        chk("full_stall_noack", ack_cnt - a0, 0);
        chk("full_cnt", count, 4);
        @(posedge clk);
        #1;
        mem_respond();
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("full_pop_cnt", count, 3);
        chk("full_ack_wait", l2_ack, 0);
        @(negedge clk);
        chk("full_late_ack", l2_ack, 1);
        chk("full_refill_cnt", count, 4);
      end
    join

    // Read miss outranks draining once the in-flight write completes.
    fork
      do_req(1'b0, 12'h0FF, '0);
      begin
        repeat (3) @(negedge clk);
        mem_pulse();
        @(negedge clk);
        @(negedge clk);
        chk("miss_first_stb", mem_stb, 1);
        chk("miss_first_we", mem_we, 0);
        chk("miss_first_adr", mem_adr, 12'h0FF);
        @(posedge clk);
        #1;
        mem_respond();
        @(negedge clk);
        chk("miss_ack_early", l2_ack, 0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("miss_ack_lat", l2_ack, 1);
      end
    join
    auto_mem = 1'b1;
    wait_empty();

    // Random traffic over a small address set so hits and coalescing are common.
    for (int i = 0; i < 300; i++) begin
      do_req(($urandom % 10) < 6, 12'h200 + 12'($urandom_range(0, 5)),
             {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_empty();
    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    // Reset in the middle of a memory write.
    auto_mem = 1'b0;
    do_req(1'b1, 12'h300, {4{32'h3030_3030}});
    wait_memwr();
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_cyc", mem_cyc, 0);
    chk("midrst_mem_stb", mem_stb, 0);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_full", full, 0);
    mq.delete();
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_count", count, 0);
    chk("late_ack_cyc", mem_cyc, 0);
    chk("late_ack_l2", l2_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ewb_queue.md
EWB_QUEUE -- requirements
Module: ewb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of eviction entries; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 12, line-address width.
REQ-003 Parameter LINE_W, default 128, line data width.
REQ-004 Parameter EAGER, default 1; 1 = drain whenever non-empty, 0 = drain only when L2 side idle or queue full.
REQ-005 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-006 l2_stb  input  1  L2 request valid.
REQ-007 l2_we  input  1  1 = eviction write, 0 = line read.
REQ-008 l2_adr  input  ADDR_W  request line address.
REQ-009 l2_wdat  input  LINE_W  eviction data.
REQ-010 l2_rdat  output  LINE_W  read return data, valid with l2_ack.
REQ-011 l2_ack  output  1  one-cycle completion pulse.
REQ-012 mem_cyc, mem_stb  output  1 each  memory cycle/strobe, always equal.
REQ-013 mem_we  output  1  memory write.
REQ-014 mem_adr  output  ADDR_W; mem_wdat  output  LINE_W.
REQ-015 mem_rdat  input  LINE_W; mem_ack  input  1  memory completion.
REQ-016 count  output  $clog2(DEPTH)+1  occupancy; full, empty  output  1 each.

Function
REQ-017 Storage: circular FIFO of DEPTH {valid, adr, data} entries, head/tail pointers wrap modulo DEPTH.
REQ-018 Request accepted only in a cycle with l2_stb=1 and l2_ack=0; l2_ack rises the cycle after completion; requester drops l2_stb the cycle after l2_ack.
REQ-019 Write, address matches a valid non-head-in-flight entry: data overwritten in place (coalesce), count unchanged, l2_ack next cycle.
REQ-020 Write, no match, count<DEPTH: pushed at tail, l2_ack next cycle.
REQ-021 Write, no match, full: stalled (no ack) until a pop completes; accepted the cycle after full falls.
REQ-022 Entry at head while MEM_WR is active is locked: matching writes push a new entry instead of coalescing.
REQ-023 Read, address matches any valid entry (including in-flight head): l2_rdat = youngest matching entry's data, l2_ack next cycle, no memory access.
REQ-024 Read miss: issued to memory as MEM_RD; l2_rdat registered from mem_rdat, l2_ack the cycle after mem_ack.
REQ-025 FSM states IDLE, MEM_RD, MEM_WR; one outstanding memory transaction.
REQ-026 IDLE -> MEM_RD on pending read miss (priority over drain); IDLE -> MEM_WR when non-empty and drain permitted (REQ-004); else stay.
REQ-027 MEM_RD/MEM_WR -> IDLE on mem_ack; MEM_WR pops head on mem_ack; in-flight transaction never aborted by new requests.
REQ-028 In MEM_WR: mem_we=1, mem_adr/mem_wdat = head entry, held stable until mem_ack; in MEM_RD: mem_we=0, mem_adr = l2_adr captured at acceptance.
REQ-029 Push and pop in same cycle: count unchanged, pointers both advance.
REQ-030 full = (count==DEPTH), empty = (count==0), combinational from count.

Reset
REQ-031 rst_n low: FSM IDLE, pointers 0, all valid bits 0, count 0, empty 1, full 0, l2_ack 0, mem_cyc/mem_stb/mem_we 0, l2_rdat/mem_adr/mem_wdat 0.
REQ-032 Reset mid-transaction drops mem_cyc immediately; queued data is discarded, late mem_ack after release is ignored in IDLE.

Structure
REQ-033 Package ewb_pkg holds state enum (IDLE, MEM_RD, MEM_WR) and default parameter constants.
REQ-034 Sub-module ewb_match: parallel address compare returning hit and youngest-hit index, excluding locked head when requested.

Verification
REQ-035 DEPTH=4: write 0x010,0x020 then read 0x020 with mem_ack held 0 -> l2_ack one cycle later, l2_rdat = written data, mem_stb never issued for read.
REQ-036 Write 0x030 data A, then 0x030 data B before drain -> count=1, mem write of 0x030 carries B.
REQ-037 Fill 4 entries, mem_ack stalled, 5th write -> no l2_ack; pulse mem_ack -> count 3, 5th write acked next cycle, count 4.
REQ-038 Queue non-empty, IDLE, read miss 0x0FF -> MEM_RD issued before any MEM_WR; l2_ack one cycle after mem_ack with mem_rdat value.
REQ-039 Head 0x040 in MEM_WR, write 0x040 data C -> new entry pushed, count +1, second memory write of 0x040 carries C.
REQ-040 Assert rst_n=0 during MEM_WR -> mem_cyc 0 same cycle, count 0, empty 1; EAGER=0 with l2_stb held -> no drain until full or l2_stb low.
